mc_datapath: RTL and testbench

- Datapath end of the multicycle MIPS core. Executes, cycle by cycle, the control word issued by the control unit FSM.
- Returns OpCode, Function and Zero to the control unit.
- Holds PC, IR, MDR, A, B, ALUOut and a register file. Drives one unified instruction/data memory port.

---
 rtl/mc_pkg.sv | 25 ++
 rtl/mc_alu.sv | 28 ++
 rtl/mc_datapath.sv | 119 +++++++++++
 tb/tb_mc_datapath.sv | 284 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mc_pkg.sv
// Shared constants for the multicycle MIPS datapath: ALU and operand-select codes,
// opcodes and the default word width.
package mc_pkg;

    localparam int DATA_W_DEF = 32;

    localparam logic [2:0] ALU_AND = 3'b000;
    localparam logic [2:0] ALU_OR  = 3'b001;
    localparam logic [2:0] ALU_ADD = 3'b010;
    localparam logic [2:0] ALU_SUB = 3'b110;
    localparam logic [2:0] ALU_SLT = 3'b111;

    localparam logic [1:0] SRCB_B       = 2'b00;
    localparam logic [1:0] SRCB_FOUR    = 2'b01;
    localparam logic [1:0] SRCB_IMM     = 2'b10;
    localparam logic [1:0] SRCB_IMM_SH2 = 2'b11;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_J     = 6'b000010;

endpackage

// File: rtl/mc_alu.sv
// Combinational ALU: add/sub wrap, signed slt, and/or; unknown codes give zero.
module mc_alu
    import mc_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF
) (
    input  logic [2:0]        alu_control_i,
    input  logic [DATA_W-1:0] src_a_i,
    input  logic [DATA_W-1:0] src_b_i,
    output logic [DATA_W-1:0] result_o,
    output logic              zero_o
);

    always_comb begin
        result_o = '0;
        case (alu_control_i)
            ALU_ADD: result_o = src_a_i + src_b_i;
            ALU_SUB: result_o = src_a_i - src_b_i;
            ALU_AND: result_o = src_a_i & src_b_i;
            ALU_OR:  result_o = src_a_i | src_b_i;
            ALU_SLT: result_o = {{(DATA_W-1){1'b0}}, ($signed(src_a_i) < $signed(src_b_i))};
            default: result_o = '0;
        endcase
    end

    assign zero_o = (result_o == '0);

endmodule

// File: rtl/mc_datapath.sv
// Multicycle MIPS datapath: PC, IR, MDR, A, B, ALUOut, register file and unified memory port.
// Optional jump support is enabled by defining MC_DATAPATH_JUMP_EN (adds the Jump input).
module mc_datapath
    import mc_pkg::*;
#(
    parameter int                DATA_W   = DATA_W_DEF,
    parameter int                RF_DEPTH = 32,
    parameter logic [DATA_W-1:0] RESET_PC = '0
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic [2:0]        ALUControl,
    input  logic              ALUSrcA,
    input  logic [1:0]        ALUSrcB,
    input  logic              IorD,
    input  logic              PcSrc,
    input  logic              PcWrite,
    input  logic              Branch,
    input  logic              IRWrite,
    input  logic              MemWrite,
    input  logic              RegWrite,
    input  logic              RegDes,
    input  logic              MemToReg,
`ifdef MC_DATAPATH_JUMP_EN
    input  logic              Jump,
`endif
    output logic [DATA_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic              mem_we,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic [5:0]        OpCode,
    output logic [5:0]        Function,
    output logic              Zero
);

    logic [DATA_W-1:0] pc_q, pc_d, ir_q, ir_d;
    logic [DATA_W-1:0] mdr_q, a_q, b_q, aluout_q;
    logic [DATA_W-1:0] rf_q [RF_DEPTH];

    logic [4:0]        rs_idx, rt_idx, wr_idx;
    logic [DATA_W-1:0] rf_rd_a, rf_rd_b, wr_data;
    logic [DATA_W-1:0] sign_imm, src_a, src_b, alu_result, pc_next;
    logic              pc_en;

    assign rs_idx   = ir_q[25:21];
    assign rt_idx   = ir_q[20:16];
    assign wr_idx   = RegDes ? ir_q[15:11] : ir_q[20:16];
    assign wr_data  = MemToReg ? mdr_q : aluout_q;
    assign sign_imm = {{(DATA_W-16){ir_q[15]}}, ir_q[15:0]};

    // Asynchronous reads see the pre-edge contents, so A/B get the old value on a same-edge write.
    assign rf_rd_a = (rs_idx == 5'd0) ? '0 : rf_q[rs_idx];
    assign rf_rd_b = (rt_idx == 5'd0) ? '0 : rf_q[rt_idx];

    assign src_a = ALUSrcA ? a_q : pc_q;

    always_comb begin
        src_b = b_q;
        case (ALUSrcB)
            SRCB_B:       src_b = b_q;
            SRCB_FOUR:    src_b = {{(DATA_W-3){1'b0}}, 3'd4};
            SRCB_IMM:     src_b = sign_imm;
            SRCB_IMM_SH2: src_b = {sign_imm[DATA_W-3:0], 2'b00};
            default:      src_b = b_q;
        endcase
    end

    mc_alu #(.DATA_W(DATA_W)) u_alu (
        .alu_control_i (ALUControl),
        .src_a_i       (src_a),
        .src_b_i       (src_b),
        .result_o      (alu_result),
        .zero_o        (Zero)
    );

    always_comb begin
        pc_next = PcSrc ? aluout_q : alu_result;
        pc_en   = PcWrite | (Branch & Zero);
`ifdef MC_DATAPATH_JUMP_EN
        if (Jump) begin
            pc_next = {pc_q[DATA_W-1:28], ir_q[25:0], 2'b00};
            pc_en   = 1'b1;
        end
`endif
        pc_d = pc_en ? pc_next : pc_q;
        ir_d = IRWrite ? mem_rdata : ir_q;
    end

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            pc_q     <= RESET_PC;
            ir_q     <= '0;
            mdr_q    <= '0;
            a_q      <= '0;
            b_q      <= '0;
            aluout_q <= '0;
            for (int i = 0; i < RF_DEPTH; i++) begin
                rf_q[i] <= '0;
            end
        end else begin
            pc_q     <= pc_d;
            ir_q     <= ir_d;
            mdr_q    <= mem_rdata;
            a_q      <= rf_rd_a;
            b_q      <= rf_rd_b;
            aluout_q <= alu_result;
            if (RegWrite && (wr_idx != 5'd0)) begin
                rf_q[wr_idx] <= wr_data;
            end
        end
    end

    assign mem_addr  = IorD ? aluout_q : pc_q;
    assign mem_wdata = b_q;
    assign mem_we    = MemWrite;
    assign OpCode    = ir_q[31:26];
    assign Function  = ir_q[5:0];

endmodule

// File: tb/tb_mc_datapath.sv
// Bench for mc_datapath: plays the control unit and memory, checks against an ISA-level model.
// Jump checks are included when MC_DATAPATH_JUMP_EN is defined.
module tb_mc_datapath;
    import mc_pkg::*;

    logic        clock = 1'b0;
    logic        reset_n;
    logic [2:0]  ALUControl;
    logic        ALUSrcA, IorD, PcSrc, PcWrite, Branch, IRWrite;
    logic        MemWrite, RegWrite, RegDes, MemToReg;
    logic [1:0]  ALUSrcB;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;
    logic        mem_we, Zero;
    logic [5:0]  OpCode, Function;
`ifdef MC_DATAPATH_JUMP_EN
    logic        Jump;
`endif

    always #5 clock = ~clock;

    mc_datapath dut (
        .clock(clock), .reset_n(reset_n), .ALUControl(ALUControl), .ALUSrcA(ALUSrcA),
        .ALUSrcB(ALUSrcB), .IorD(IorD), .PcSrc(PcSrc), .PcWrite(PcWrite), .Branch(Branch),
        .IRWrite(IRWrite), .MemWrite(MemWrite), .RegWrite(RegWrite), .RegDes(RegDes),
        .MemToReg(MemToReg),
`ifdef MC_DATAPATH_JUMP_EN
        .Jump(Jump),
`endif
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_we(mem_we), .mem_rdata(mem_rdata),
        .OpCode(OpCode), .Function(Function), .Zero(Zero)
    );

    // Unified memory, 4 KiB, combinational read; stores applied by tick()
    logic [31:0] mem [0:1023];
    assign mem_rdata = mem[mem_addr[11:2]];

    // Reference model: architectural state only
    logic [31:0] rf_m [32];
    logic [31:0] dm_m [0:1023];
    logic [31:0] pc_m;
    logic [31:0] exp_q [$];

    int n_checks = 0;
    int n_err    = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic idle();
        ALUControl = ALU_ADD; ALUSrcA = 1'b0; ALUSrcB = SRCB_B; IorD = 1'b0;
        PcSrc = 1'b0; PcWrite = 1'b0; Branch = 1'b0; IRWrite = 1'b0;
        MemWrite = 1'b0; RegWrite = 1'b0; RegDes = 1'b0; MemToReg = 1'b0;
`ifdef MC_DATAPATH_JUMP_EN
        Jump = 1'b0;
`endif
    endtask

    task automatic tick();
        logic        do_wr;
        logic [31:0] wa, wd;
        #1;
        do_wr = mem_we; wa = mem_addr; wd = mem_wdata;
        @(posedge clock); #1;
        if (do_wr === 1'b1) mem[wa[11:2]] = wd;
    endtask

    task automatic model_reset();
        for (int i = 0; i < 32; i++) rf_m[i] = '0;
        pc_m = '0;
    endtask

    function automatic logic [31:0] enc_i(logic [5:0] op, logic [4:0] rs, logic [4:0] rt, logic [15:0] imm);
        return {op, rs, rt, imm};
    endfunction

    function automatic logic [31:0] enc_r(logic [4:0] rs, logic [4:0] rt, logic [4:0] rd, logic [5:0] fn);
        return {OP_RTYPE, rs, rt, rd, 5'd0, fn};
    endfunction

    function automatic logic [2:0] alu_of(logic [5:0] fn);
        case (fn)
            6'h20:   return ALU_ADD;
            6'h22:   return ALU_SUB;
            6'h24:   return ALU_AND;
            6'h25:   return ALU_OR;
            default: return ALU_SLT;
        endcase
    endfunction

    function automatic logic [31:0] r_result(logic [5:0] fn, logic [31:0] a, logic [31:0] b);
        case (fn)
            6'h20:   return a + b;
            6'h22:   return a - b;
            6'h24:   return a & b;
            6'h25:   return a | b;
            default: return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
        endcase
    endfunction

    // Issues the full control sequence for one instruction and advances the model.
    task automatic run_instr(input logic [31:0] instr);
        logic [5:0]  op, fn;
        logic [4:0]  rs, rt, rd;
        logic [31:0] a, b, simm, res;
        op = instr[31:26]; fn = instr[5:0];
        rs = instr[25:21]; rt = instr[20:16]; rd = instr[15:11];
        simm = {{16{instr[15]}}, instr[15:0]};
        a = rf_m[rs]; b = rf_m[rt];
        mem[pc_m[11:2]] = instr;

        idle(); ALUSrcB = SRCB_FOUR; IRWrite = 1'b1; PcWrite = 1'b1;
        #1 chk("fetch_addr", mem_addr, pc_m);
        tick();
        pc_m = pc_m + 32'd4;
        chk("opcode", {26'd0, OpCode}, {26'd0, op});
        chk("funct", {26'd0, Function}, {26'd0, fn});

        idle(); ALUSrcB = SRCB_IMM_SH2;
`ifdef MC_DATAPATH_JUMP_EN
        if (op == OP_J) Jump = 1'b1;
`endif
        exp_q.push_back(b);
        tick();
        chk("b_reg", mem_wdata, exp_q.pop_front());
        if (op == OP_J) pc_m = {pc_m[31:28], instr[25:0], 2'b00};

        case (op)
            OP_RTYPE, OP_ADDI: begin
                res = (op == OP_RTYPE) ? r_result(fn, a, b) : a + simm;
                idle(); ALUSrcA = 1'b1;
                if (op == OP_RTYPE) ALUControl = alu_of(fn);
                else ALUSrcB = SRCB_IMM;
                #1 chk("exec_zero", {31'd0, Zero}, {31'd0, res == 32'd0});
                tick();
                idle(); RegWrite = 1'b1; RegDes = (op == OP_RTYPE);
                tick();
                if (op == OP_RTYPE) begin
                    if (rd != 5'd0) rf_m[rd] = res;
                end else if (rt != 5'd0) begin
                    rf_m[rt] = res;
                end
            end
            OP_LW, OP_SW: begin
                res = a + simm;
                idle(); ALUSrcA = 1'b1; ALUSrcB = SRCB_IMM;
                tick();
                IorD = 1'b1; MemWrite = (op == OP_SW);
                #1 chk("mem_addr", mem_addr, res);
                chk("mem_we", {31'd0, mem_we}, {31'd0, op == OP_SW});
                if (op == OP_SW) chk("sw_data", mem_wdata, b);
                tick();
                if (op == OP_SW) begin
                    dm_m[res[11:2]] = b;
                end else begin
                    idle(); RegWrite = 1'b1; MemToReg = 1'b1;
                    tick();
                    if (rt != 5'd0) rf_m[rt] = dm_m[res[11:2]];
                end
            end
            OP_BEQ: begin
                idle(); ALUSrcA = 1'b1; ALUControl = ALU_SUB; Branch = 1'b1; PcSrc = 1'b1;
                #1 chk("beq_zero", {31'd0, Zero}, {31'd0, a == b});
                tick();
                if (a == b) pc_m = pc_m + (simm << 2);
            end
            default: ;
        endcase
        idle();
    endtask

    task automatic probe(input logic [4:0] r);
        run_instr(enc_r(r, r, 5'd0, 6'h24));
    endtask

    int kind;
    logic [4:0]  r_s, r_t, r_d;
    logic [5:0]  fns [5] = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h2A};

    initial begin
        for (int i = 0; i < 1024; i++) begin
            mem[i] = '0;
            dm_m[i] = '0;
        end
        idle();
        reset_n = 1'b0;
        tick(); tick();
        reset_n = 1'b1;
        model_reset();

        // Reset state
        #1 chk("rst_pc", mem_addr, 32'h0);
        chk("rst_opcode", {26'd0, OpCode}, 32'h0);
        chk("rst_funct", {26'd0, Function}, 32'h0);
        chk("rst_b", mem_wdata, 32'h0);
        IorD = 1'b1;
        #1 chk("rst_aluout", mem_addr, 32'h0);
        IorD = 1'b0; MemWrite = 1'b1;
        #1 chk("we_follow_1", {31'd0, mem_we}, 32'd1);
        MemWrite = 1'b0;
        #1 chk("we_follow_0", {31'd0, mem_we}, 32'd0);

        // Single fetch, then reset during the lw memory cycle
        mem[0] = 32'h8C220008;
        ALUSrcB = SRCB_FOUR; IRWrite = 1'b1; PcWrite = 1'b1;
        tick();
        idle();
        #1 chk("fetch_pc4", mem_addr, 32'h4);
        chk("fetch_op", {26'd0, OpCode}, {26'd0, OP_LW});
        ALUSrcB = SRCB_IMM_SH2; tick();
        idle(); ALUSrcA = 1'b1; ALUSrcB = SRCB_IMM; tick();
        IorD = 1'b1; RegWrite = 1'b1; MemToReg = 1'b1; reset_n = 1'b0;
        tick();
        reset_n = 1'b1; idle();
        #1 chk("midrst_pc", mem_addr, 32'h0);
        chk("midrst_ir", {26'd0, OpCode}, 32'h0);
        model_reset();

        // lw through base register
        mem[32'h108 >> 2] = 32'hDEADBEEF;
        dm_m[32'h108 >> 2] = 32'hDEADBEEF;
        run_instr(enc_i(OP_ADDI, 5'd0, 5'd1, 16'h0100));
        run_instr(32'h8C220008);
        probe(5'd2);

        // Wrapping add, signed slt, register 0 stays zero
        run_instr(enc_i(OP_ADDI, 5'd0, 5'd1, 16'd7));
        run_instr(enc_i(OP_ADDI, 5'd0, 5'd2, 16'hFFFF));
        run_instr(enc_r(5'd1, 5'd2, 5'd3, 6'h20));
        run_instr(enc_r(5'd2, 5'd1, 5'd4, 6'h2A));
        probe(5'd3);
        probe(5'd4);
        run_instr(enc_r(5'd1, 5'd1, 5'd0, 6'h20));
        probe(5'd0);

        // beq taken from PC=8 with imm=3, then not taken
        idle(); reset_n = 1'b0; tick(); reset_n = 1'b1;
        model_reset();
        run_instr(enc_i(OP_ADDI, 5'd0, 5'd5, 16'd5));
        run_instr(enc_i(OP_ADDI, 5'd0, 5'd6, 16'd5));
        run_instr(enc_i(OP_BEQ, 5'd5, 5'd6, 16'd3));
        #1 chk("beq_taken", mem_addr, 32'h18);
        run_instr(enc_i(OP_BEQ, 5'd5, 5'd0, 16'd2));
        #1 chk("beq_not_taken", mem_addr, 32'h1C);

        // Random instruction mix over a data window at 0x800
        for (int i = 512; i < 640; i++) begin
            mem[i] = $urandom;
            dm_m[i] = mem[i];
        end
        run_instr(enc_i(OP_ADDI, 5'd0, 5'd7, 16'h0800));
        for (int n = 0; n < 40; n++) begin
            kind = $urandom_range(0, 4);
            r_s = 5'($urandom_range(0, 6));
            r_t = 5'($urandom_range(1, 6));
            r_d = 5'($urandom_range(1, 6));
            case (kind)
                0: run_instr(enc_i(OP_ADDI, r_s, r_t, 16'($urandom)));
                1: run_instr(enc_r(r_s, r_t, r_d, fns[$urandom_range(0, 4)]));
                2: run_instr(enc_i(OP_LW, 5'd7, r_t, 16'($urandom_range(0, 127) * 4)));
                3: run_instr(enc_i(OP_SW, 5'd7, r_t, 16'($urandom_range(0, 127) * 4)));
                default: begin
                    if ($urandom_range(0, 1) == 1) r_t = r_s;
                    run_instr(enc_i(OP_BEQ, r_s, r_t, 16'($urandom_range(0, 3))));
                end
            endcase
        end
        for (int r = 1; r < 8; r++) probe(5'(r));

`ifdef MC_DATAPATH_JUMP_EN
        run_instr({OP_J, 26'h0000040});
        #1 chk("jump_pc", mem_addr, 32'h100);
        probe(5'd1);
`endif

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
